tone_detect: RTL
================

Name: tone_detect

Overview:
- Receive-side counterpart of the square-wave sound generator. Measures the frequency of a 1-bit tone signal over fixed millisecond gate windows.
- Classifies the measured frequency against the four game tones.
- Used on the bench and in loopback self-test to recover which game tone (if any) the sound output is playing.

Parameters:
- GATE_MS, 250, gate window length in ms. Legal values: 125, 250, 500, 1000. Scale factor 1000/GATE_MS is a power of two (8, 4, 2, 1).
- TOLERANCE, 8, maximum absolute Hz error for a tone match.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ticks_per_milli  input  16  clk cycles per millisecond; 0 is treated as 1
- sound_in  input  1  square-wave tone, asynchronous to clk
- freq  output  10  last measured frequency in Hz, saturating at 1023
- freq_valid  output  1  one-cycle pulse when freq and the classification outputs update
- overflow  output  1  last window's scaled count exceeded 1023
- silent  output  1  last window saw zero rising edges
- tone_match  output  1  last measurement is within TOLERANCE of a game tone
- tone_idx  output  2  index of the matched tone; 0 when tone_match=0

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, all counters 0, FSM in S_COUNT.
- Input conditioning:
  - sound_in passes through a 2-FF synchronizer, then a rising-edge detector.
  - An edge is counted 3 cycles after the input transition.
- Millisecond tick:
  - Tick counter runs 0..ticks_per_milli-1 and emits a one-cycle ms pulse on wrap.
  - A ms counter counts pulses up to GATE_MS. window_end is asserted on the pulse that makes it reach GATE_MS; the ms counter then restarts at 0.
- Edge counter: 11-bit, saturating at 2047.
  - On window_end the count is snapshotted.
  - The counter then restarts at 1 if an edge coincides with window_end, else 0. No edges are lost between windows.
- FSM, continuous, never stalls counting:
  - S_COUNT: wait for window_end, snapshot the count, go to S_SCALE.
  - S_SCALE: scaled = snapshot << log2(1000/GATE_MS), computed at 14 bits. freq = min(scaled, 1023). overflow = scaled > 1023. silent = snapshot == 0. Go to S_CLASSIFY.
  - S_CLASSIFY: compare freq with GAME_TONES 196, 262, 330, 784. Match when |freq - tone| <= TOLERANCE, unsigned-safe difference. The lowest matching index wins. A match is suppressed if silent or overflow. Pulse freq_valid, return to S_COUNT.
- Latency: freq_valid is high exactly 2 cycles after the window_end cycle.
- freq, overflow, silent, tone_match and tone_idx hold their values between pulses.
- A window_end during S_SCALE/S_CLASSIFY cannot occur, since GATE_MS*ticks >= 125 cycles.
- ticks_per_milli may change at any time:
  - The current tick count is compared with >= (new value - 1), so a reduction wraps immediately rather than running to 65535.
- Reset mid-window discards the partial measurement. No freq_valid until a full window completes after reset release.

Optional Feature:
- TONE_DETECT_STABLE_EN
  - When defined: tone_match asserts only when the current and previous windows classified to the same tone_idx (both matching). The first matching window after a mismatch, silence or reset gives tone_match=0 with tone_idx showing the candidate.
  - When undefined: tone_match follows the single-window classification directly.
  - freq, silent and overflow are unaffected either way.

Decomposition:
- Shared package simon_pkg holds:
  - GAME_TONES[0:3] as 10-bit constants
  - the 2-bit tone index typedef
  - legal GATE_MS values
- The same package later serves the generator side.
- Sub-module milli_tick (tick counter producing the ms pulse from ticks_per_milli) is natural and reusable by the game FSM.

Test Plan (ticks_per_milli=4, GATE_MS=250, so 1000-cycle windows):
- Exactly 65 rising edges per window -> freq=260, tone_match=1, tone_idx=1, freq_valid 2 cycles after window_end.
- 196 edges per window -> freq=784, tone_idx=3, match. 10 edges -> freq=40, tone_match=0, tone_idx=0.
- sound_in held low for a window -> silent=1, freq=0, tone_match=0. 300 edges -> overflow=1, freq=1023, tone_match=0.
- Edge placed on the window_end cycle -> counted in the next window; totals of 49/50 across adjacent windows -> freq 196 then 200, both give tone_idx=0.
- rst asserted asynchronously mid-window (between clock edges) -> outputs 0 immediately; first freq_valid exactly 1002 cycles after release.
- With TONE_DETECT_STABLE_EN: 83 then 83 edges (freq 332) -> tone_match 0 then 1, tone_idx=2. Without the macro -> tone_match=1 on the first window.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared tone constants and helpers for the sound generator and tone detector
// Contents: GAME_TONES table, tone index type, legal gate window lengths,
// tone_detect FSM states, gate-length-to-shift helper and unsigned distance helper.
package simon_pkg;
    typedef logic [1:0] tone_idx_t;
    typedef enum logic [1:0] {S_COUNT, S_SCALE, S_CLASSIFY} td_state_t;
    localparam logic [9:0] GAME_TONES [0:3] = '{10'd196, 10'd262, 10'd330, 10'd784};
    localparam int GATE_MS_LEGAL [0:3] = '{125, 250, 500, 1000};

    // Window count to Hz is a left shift by log2(1000/GATE_MS); unknown lengths fall back to 0.
    function automatic int gate_shift(input int gate_ms);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            if (gate_ms == GATE_MS_LEGAL[i]) s = 3 - i;
        return s;
    endfunction

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return a > b ? a - b : b - a;
    endfunction
endpackage

// File: rtl/tone_detect_if.sv
// tone_detect_if: measurement result bus of the tone detector
// master: driven by tone_detect; slave: consumers of the measurement.
interface tone_detect_if;
    import simon_pkg::*;
    logic [9:0] freq;
    logic       freq_valid;
    logic       overflow;
    logic       silent;
    logic       tone_match;
    tone_idx_t  tone_idx;
    modport master(output freq, freq_valid, overflow, silent, tone_match, tone_idx);
    modport slave(input freq, freq_valid, overflow, silent, tone_match, tone_idx);
endinterface

// File: rtl/tone_detect_milli_tick.sv
// milli_tick: one-cycle ms pulse every ticks_per_milli clk cycles
// Ports: clk, rst (async, active high), ticks_per_milli (0 treated as 1), ms (registered pulse).
module milli_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    output logic        ms
);
    logic [15:0] cnt;
    logic [15:0] last;
    logic        wrap;
    assign last = ticks_per_milli == 16'd0 ? 16'd0 : ticks_per_milli - 16'd1;
    // >= so that lowering ticks_per_milli below the current count wraps at once
    assign wrap = cnt >= last;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            ms  <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 16'd1;
            ms  <= wrap;
        end
endmodule

// File: rtl/tone_detect.sv
// tone_detect: measures a 1-bit tone's frequency over GATE_MS windows and classifies it against GAME_TONES
// Ports: clk, rst (async, active high), ticks_per_milli (clk cycles per ms), sound_in (async square wave),
// res (tone_detect_if.master: freq, freq_valid, overflow, silent, tone_match, tone_idx).
// Optional: define TONE_DETECT_STABLE_EN to require two consecutive windows on the same tone for tone_match.
module tone_detect import simon_pkg::*; #(
    parameter int GATE_MS   = 250,
    parameter int TOLERANCE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   ticks_per_milli,
    input  logic          sound_in,
    tone_detect_if.master res
);
    localparam int SHIFT = gate_shift(GATE_MS);
    logic [2:0]  sync;
    logic        edge_hit;
    logic        ms;
    logic [9:0]  ms_cnt;
    logic        window_end;
    logic [10:0] edge_cnt;
    logic [10:0] snap;
    td_state_t   state;
    logic [13:0] scaled;
    logic [9:0]  freq_n;
    logic        ovf_n;
    logic        silent_n;
    logic        hit_n;
    tone_idx_t   idx_n;
`ifdef TONE_DETECT_STABLE_EN
    logic        prev_hit;
    tone_idx_t   prev_idx;
`endif

    milli_tick u_tick (.clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli), .ms(ms));

    // sync[1:0] is the synchronizer, sync[2] the previous synchronized sample
    assign edge_hit   = sync[1] & ~sync[2];
    assign window_end = ms && ms_cnt == 10'(GATE_MS - 1);
    assign scaled     = {3'b000, snap} << SHIFT;
    assign ovf_n      = scaled > 14'd1023;
    assign freq_n     = ovf_n ? 10'd1023 : scaled[9:0];
    assign silent_n   = snap == 11'd0;

    // Descending scan so the lowest matching index wins
    always_comb begin
        hit_n = 1'b0;
        idx_n = '0;
        for (int i = 3; i >= 0; i--)
            if (abs_diff(freq_n, GAME_TONES[i]) <= 10'(TOLERANCE) && !silent_n && !ovf_n) begin
                hit_n = 1'b1;
                idx_n = 2'(i);
            end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync     <= '0;
            ms_cnt   <= '0;
            edge_cnt <= '0;
        end else begin
            sync     <= {sync[1:0], sound_in};
            ms_cnt   <= window_end ? '0 : ms ? ms_cnt + 10'd1 : ms_cnt;
            // An edge landing on window_end opens the next window's count
            edge_cnt <= window_end ? {10'd0, edge_hit} : (edge_hit && edge_cnt != '1) ? edge_cnt + 11'd1 : edge_cnt;
        end

    // Results register as S_SCALE ends so freq_valid is seen 2 cycles after window_end;
    // S_CLASSIFY is the cycle in which the pulse and the new classification are visible.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state          <= S_COUNT;
            snap           <= '0;
            res.freq       <= '0;
            res.freq_valid <= 1'b0;
            res.overflow   <= 1'b0;
            res.silent     <= 1'b0;
            res.tone_match <= 1'b0;
            res.tone_idx   <= '0;
`ifdef TONE_DETECT_STABLE_EN
            prev_hit       <= 1'b0;
            prev_idx       <= '0;
`endif
        end else begin
            res.freq_valid <= 1'b0;
            case (state)
                S_COUNT: if (window_end) begin
                    snap  <= edge_cnt;
                    state <= S_SCALE;
                end
                S_SCALE: begin
                    res.freq       <= freq_n;
                    res.overflow   <= ovf_n;
                    res.silent     <= silent_n;
                    res.tone_idx   <= idx_n;
`ifdef TONE_DETECT_STABLE_EN
                    res.tone_match <= hit_n && prev_hit && prev_idx == idx_n;
                    prev_hit       <= hit_n;
                    prev_idx       <= idx_n;
`else
                    res.tone_match <= hit_n;
`endif
                    res.freq_valid <= 1'b1;
                    state          <= S_CLASSIFY;
                end
                default: state <= S_COUNT;
            endcase
        end
endmodule
